// File: rtl/class_buf_ram_dp.sv
`default_nettype none
// ============================================================================
// class_buf_ram_dp : true-dual-port size-classed burst packet buffer
// Revision 1.0 - initial release
// ============================================================================

module class_buf_ram_dp_port #(
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 16,
  parameter int CLS_W   = 2,
  parameter int RD_LAT  = 2,
  parameter int OFIFO_D = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_wr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              err_len,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = ADDR_W - CLS_W;
  localparam int CNT_W = 1 << CLS_W;
  localparam int PTR_W = (OFIFO_D > 1) ? $clog2(OFIFO_D) : 1;
  localparam int CRD_W = $clog2(OFIFO_D + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              err_len_q, err_len_d;
  logic [CRD_W-1:0]  credit_q, credit_d;
  logic [RD_LAT-1:0] pvld_q, pvld_d;
  logic [RD_LAT-1:0] plast_q, plast_d;
  logic [CRD_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [DATA_W-1:0] fifo_data_q [OFIFO_D];
  logic              fifo_last_q [OFIFO_D];

  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              is_final;
  logic              issue;
  logic              pop;
  logic              push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OFIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Offset wraps inside the class region; the class bits are held constant.
  assign beat_addr = {base_q[ADDR_W-1 -: CLS_W], base_q[OFF_W-1:0] + OFF_W'(idx_q)};
  assign is_final  = (idx_q == beats_q - CNT_W'(1));
  // Credit covers beats in the memory pipeline plus beats parked in the FIFO.
  assign issue     = (state_q == S_RD) && (credit_q < CRD_W'(OFIFO_D));
  assign push      = pvld_q[RD_LAT-1];
  assign pop       = rd_valid && rd_ready;

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WR);
  assign err_len   = err_len_q;
  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? fifo_data_q[rptr_q] : '0;
  assign rd_last   = rd_valid && fifo_last_q[rptr_q];

  assign mem_we    = wr_valid && wr_ready;
  assign mem_waddr = beat_addr;
  assign mem_wdata = wr_data;
  assign mem_re    = issue;
  assign mem_raddr = beat_addr;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beats_d   = beats_q;
    idx_d     = idx_q;
    err_len_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d  = cmd_addr;
          beats_d = CNT_W'(1) << cmd_addr[ADDR_W-1 -: CLS_W];
          idx_d   = '0;
          state_d = cmd_wr ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (wr_valid) begin
          idx_d     = idx_q + CNT_W'(1);
          err_len_d = is_final ^ wr_last;
          if (is_final || wr_last) state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (issue) begin
          idx_d = idx_q + CNT_W'(1);
          if (is_final) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && rd_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credit_d   = credit_q + CRD_W'(issue) - CRD_W'(pop);
    count_d    = count_q + CRD_W'(push) - CRD_W'(pop);
    wptr_d     = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d     = pop ? ptr_inc(rptr_q) : rptr_q;
    pvld_d     = pvld_q;
    plast_d    = plast_q;
    pvld_d[0]  = issue;
    plast_d[0] = is_final;
    for (int k = 1; k < RD_LAT; k++) begin
      pvld_d[k]  = pvld_q[k-1];
      plast_d[k] = plast_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      beats_q   <= '0;
      idx_q     <= '0;
      err_len_q <= 1'b0;
      credit_q  <= '0;
      pvld_q    <= '0;
      plast_q   <= '0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      beats_q   <= beats_d;
      idx_q     <= idx_d;
      err_len_q <= err_len_d;
      credit_q  <= credit_d;
      pvld_q    <= pvld_d;
      plast_q   <= plast_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wptr_q] <= pipe_data;
      fifo_last_q[wptr_q] <= plast_q[RD_LAT-1];
    end
  end

  // mem_rdata is already the first registered stage of the read latency.
  if (RD_LAT == 1) begin : g_lat1
    assign pipe_data = mem_rdata;
  end else begin : g_latn
    logic [DATA_W-1:0] pdata_q [RD_LAT-1];
    always_ff @(posedge clk) begin
      pdata_q[0] <= mem_rdata;
      for (int k = 1; k < RD_LAT - 1; k++) pdata_q[k] <= pdata_q[k-1];
    end
    assign pipe_data = pdata_q[RD_LAT-2];
  end

endmodule

module class_buf_ram_dp #(
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 16,
  parameter int CLS_W   = 2,
  parameter int RD_LAT  = 2,
  parameter int OFIFO_D = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_a,
  output logic              cmd_ready_a,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic              cmd_wr_a,
  input  logic              wr_valid_a,
  output logic              wr_ready_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_last_a,
  output logic              rd_valid_a,
  input  logic              rd_ready_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_last_a,
  output logic              err_len_a,
  input  logic              cmd_valid_b,
  output logic              cmd_ready_b,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic              cmd_wr_b,
  input  logic              wr_valid_b,
  output logic              wr_ready_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              wr_last_b,
  output logic              rd_valid_b,
  input  logic              rd_ready_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_last_b,
  output logic              err_len_b,
  output logic              err_coll
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              we_a, we_b, re_a, re_b;
  logic [ADDR_W-1:0] waddr_a, waddr_b, raddr_a, raddr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
  logic              coll;
  logic              err_coll_q, err_coll_d;

  (* ram_style = "ultra" *) logic [DATA_W-1:0] mem [DEPTH];

  class_buf_ram_dp_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLS_W(CLS_W), .RD_LAT(RD_LAT), .OFIFO_D(OFIFO_D)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_addr(cmd_addr_a), .cmd_wr(cmd_wr_a),
    .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_data(wr_data_a), .wr_last(wr_last_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_data(rd_data_a), .rd_last(rd_last_a),
    .err_len(err_len_a),
    .mem_we(we_a), .mem_waddr(waddr_a), .mem_wdata(wdata_a),
    .mem_re(re_a), .mem_raddr(raddr_a), .mem_rdata(rdata_a_q)
  );

  class_buf_ram_dp_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLS_W(CLS_W), .RD_LAT(RD_LAT), .OFIFO_D(OFIFO_D)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_addr(cmd_addr_b), .cmd_wr(cmd_wr_b),
    .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_data(wr_data_b), .wr_last(wr_last_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b), .rd_last(rd_last_b),
    .err_len(err_len_b),
    .mem_we(we_b), .mem_waddr(waddr_b), .mem_wdata(wdata_b),
    .mem_re(re_b), .mem_raddr(raddr_b), .mem_rdata(rdata_b_q)
  );

  assign coll       = we_a && we_b && (waddr_a == waddr_b);
  assign err_coll_d = coll;
  assign err_coll   = err_coll_q;

  // Port A wins a same-address write; reads sample pre-write contents.
  always_ff @(posedge clk) begin
    if (we_b && !coll) mem[waddr_b] <= wdata_b;
    if (we_a)          mem[waddr_a] <= wdata_a;
    if (re_a)          rdata_a_q    <= mem[raddr_a];
    if (re_b)          rdata_b_q    <= mem[raddr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_coll_q <= 1'b0;
    else        err_coll_q <= err_coll_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_class_buf_ram_dp.sv
`default_nettype none
// ============================================================================
// tb_class_buf_ram_dp : scoreboard bench for class_buf_ram_dp
// Revision 1.0 - initial release
// ============================================================================

module tb_class_buf_ram_dp;

  localparam int DW     = 512;
  localparam int AW     = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_a, cmd_ready_a, cmd_wr_a, wr_valid_a, wr_ready_a, wr_last_a;
  logic          rd_valid_a, rd_ready_a, rd_last_a, err_len_a;
  logic [AW-1:0] cmd_addr_a;
  logic [DW-1:0] wr_data_a, rd_data_a;
  logic          cmd_valid_b, cmd_ready_b, cmd_wr_b, wr_valid_b, wr_ready_b, wr_last_b;
  logic          rd_valid_b, rd_ready_b, rd_last_b, err_len_b;
  logic [AW-1:0] cmd_addr_b;
  logic [DW-1:0] wr_data_b, rd_data_b;
  logic          err_coll;

  typedef struct packed { logic l; logic [DW-1:0] d; } beat_t;
  beat_t         exp_a[$];
  beat_t         exp_b[$];
  int            n_vec  = 0;
  int            n_miss = 0;
  logic          held_v [2];
  logic [DW-1:0] held_d [2];
  int            cnt_elen_a = 0, cnt_elen_b = 0, cnt_coll = 0;
  bit            rnd_en = 0;

  always #5 clk = ~clk;

  class_buf_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .CLS_W(2), .RD_LAT(RD_LAT), .OFIFO_D(RD_LAT + 2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_a(cmd_valid_a), .cmd_ready_a(cmd_ready_a), .cmd_addr_a(cmd_addr_a), .cmd_wr_a(cmd_wr_a),
    .wr_valid_a(wr_valid_a), .wr_ready_a(wr_ready_a), .wr_data_a(wr_data_a), .wr_last_a(wr_last_a),
    .rd_valid_a(rd_valid_a), .rd_ready_a(rd_ready_a), .rd_data_a(rd_data_a), .rd_last_a(rd_last_a),
    .err_len_a(err_len_a),
    .cmd_valid_b(cmd_valid_b), .cmd_ready_b(cmd_ready_b), .cmd_addr_b(cmd_addr_b), .cmd_wr_b(cmd_wr_b),
    .wr_valid_b(wr_valid_b), .wr_ready_b(wr_ready_b), .wr_data_b(wr_data_b), .wr_last_b(wr_last_b),
    .rd_valid_b(rd_valid_b), .rd_ready_b(rd_ready_b), .rd_data_b(rd_data_b), .rd_last_b(rd_last_b),
    .err_len_b(err_len_b),
    .err_coll(err_coll)
  );

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_to(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timeout, required handshake never seen", name);
  endfunction

  task automatic push_exp(input int p, input logic [DW-1:0] d, input logic l);
    beat_t e;
    e.d = d;
    e.l = l;
    if (p == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
  endtask

  // Monitor: pops the scoreboard on each read handshake, checks stall stability.
  task automatic mon_port(input int p, input logic v, input logic r, input logic [DW-1:0] d, input logic l);
    beat_t e;
    string nm;
    nm = (p == 0) ? "a" : "b";
    if (held_v[p]) begin
      chk({"stall_valid_", nm}, DW'(v), DW'(1));
      chk({"stall_data_", nm}, d, held_d[p]);
    end
    if (v && r) begin
      if ((p == 0 && exp_a.size() == 0) || (p == 1 && exp_b.size() == 0)) begin
        chk({"unexpected_beat_", nm}, DW'(1), DW'(0));
      end else begin
        e = (p == 0) ? exp_a.pop_front() : exp_b.pop_front();
        chk({"rd_data_", nm}, d, e.d);
        chk({"rd_last_", nm}, DW'(l), DW'(e.l));
      end
    end
    held_v[p] = v && !r;
    held_d[p] = d;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_port(0, rd_valid_a, rd_ready_a, rd_data_a, rd_last_a);
      mon_port(1, rd_valid_b, rd_ready_b, rd_data_b, rd_last_b);
      cnt_elen_a += int'(err_len_a);
      cnt_elen_b += int'(err_len_b);
      cnt_coll   += int'(err_coll);
    end else begin
      held_v[0] = 1'b0;
      held_v[1] = 1'b0;
    end
  end

  task automatic do_cmd(input int p, input logic [AW-1:0] addr, input logic wr);
    bit ok = 0;
    if (p == 0) begin cmd_valid_a = 1'b1; cmd_addr_a = addr; cmd_wr_a = wr; end
    else        begin cmd_valid_b = 1'b1; cmd_addr_b = addr; cmd_wr_b = wr; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((p == 0) ? cmd_ready_a : cmd_ready_b) ok = 1;
      else @(posedge clk);
    end
    @(posedge clk);
    #1;
    if (!ok) fail_to("cmd_accept");
    if (p == 0) cmd_valid_a = 1'b0;
    else        cmd_valid_b = 1'b0;
  endtask

  task automatic wr_beat(input int p, input logic [DW-1:0] d, input logic last);
    bit ok = 0;
    if (p == 0) begin wr_valid_a = 1'b1; wr_data_a = d; wr_last_a = last; end
    else        begin wr_valid_b = 1'b1; wr_data_b = d; wr_last_b = last; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((p == 0) ? wr_ready_a : wr_ready_b) ok = 1;
      else @(posedge clk);
    end
    @(posedge clk);
    #1;
    if (!ok) fail_to("wr_accept");
    if (p == 0) begin wr_valid_a = 1'b0; wr_last_a = 1'b0; end
    else        begin wr_valid_b = 1'b0; wr_last_b = 1'b0; end
  endtask

  task automatic wait_drain(input int p);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #2;
      if (p == 0) done = (exp_a.size() == 0) && cmd_ready_a;
      else        done = (exp_b.size() == 0) && cmd_ready_b;
    end
    if (!done) fail_to((p == 0) ? "drain_a" : "drain_b");
  endtask

  task automatic write_burst(input int p, input logic [AW-1:0] addr, input int n, input logic [DW-1:0] base);
    do_cmd(p, addr, 1'b1);
    for (int i = 0; i < n; i++) wr_beat(p, base + DW'(i), (i == n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    cmd_valid_a = 0; cmd_addr_a = '0; cmd_wr_a = 0; wr_valid_a = 0; wr_data_a = '0; wr_last_a = 0;
    cmd_valid_b = 0; cmd_addr_b = '0; cmd_wr_b = 0; wr_valid_b = 0; wr_data_b = '0; wr_last_b = 0;
    rd_ready_a = 1'b1;
    rd_ready_b = 1'b1;
    held_v[0] = 0; held_v[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready_a", DW'(cmd_ready_a), DW'(1));
    chk("rst_cmd_ready_b", DW'(cmd_ready_b), DW'(1));
    chk("rst_wr_ready_a", DW'(wr_ready_a), DW'(0));
    chk("rst_wr_ready_b", DW'(wr_ready_b), DW'(0));
    chk("rst_rd_valid_a", DW'(rd_valid_a), DW'(0));
    chk("rst_rd_valid_b", DW'(rd_valid_b), DW'(0));
    chk("rst_rd_data_a", rd_data_a, '0);
    chk("rst_rd_last_b", DW'(rd_last_b), DW'(0));
    chk("rst_err", DW'({err_len_a, err_len_b, err_coll}), DW'(0));

    // Single-beat write then read with latency and cmd_ready return.
    @(posedge clk); #1;
    write_burst(0, 16'h0010, 1, {64{8'hA5}});
    push_exp(0, {64{8'hA5}}, 1'b1);
    do_cmd(0, 16'h0010, 1'b0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (rd_valid_a) break;
      @(posedge clk);
      lat++;
    end
    chk("rd_latency", DW'(lat), DW'(RD_LAT + 1));
    chk("cmd_ready_busy", DW'(cmd_ready_a), DW'(0));
    @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_back", DW'(cmd_ready_a), DW'(1));
    wait_drain(0);

    // 8-beat write on A, read back on B.
    write_burst(0, 16'hC000, 8, '0);
    for (int i = 0; i < 8; i++) push_exp(1, DW'(i), (i == 7));
    do_cmd(1, 16'hC000, 1'b0);
    wait_drain(1);

    // Class-2 wrap: BFFE, BFFF, 8000, 8001.
    write_burst(0, 16'h8000, 4, DW'(32'h8000));
    write_burst(1, 16'hBFFC, 4, DW'(32'hBFFC));
    push_exp(0, DW'(32'hBFFE), 1'b0);
    push_exp(0, DW'(32'hBFFF), 1'b0);
    push_exp(0, DW'(32'h8000), 1'b0);
    push_exp(0, DW'(32'h8001), 1'b1);
    do_cmd(0, 16'hBFFE, 1'b0);
    wait_drain(0);

    // 8-beat read under random backpressure.
    for (int i = 0; i < 8; i++) push_exp(1, DW'(i), (i == 7));
    rnd_en = 1;
    fork
      begin
        while (rnd_en) begin
          @(posedge clk);
          #1;
          if (rnd_en) rd_ready_b = 1'($urandom_range(0, 1));
        end
      end
    join_none
    do_cmd(1, 16'hC000, 1'b0);
    wait_drain(1);
    rnd_en = 0;
    rd_ready_b = 1'b1;

    // Early wr_last on beat 1 of a 4-beat write.
    write_burst(0, 16'h8010, 4, DW'(32'h5000));
    do_cmd(0, 16'h8010, 1'b1);
    wr_beat(0, DW'(32'h6000), 1'b0);
    wr_beat(0, DW'(32'h6001), 1'b1);
    @(negedge clk);
    chk("early_last_cmd_ready", DW'(cmd_ready_a), DW'(1));
    chk("early_last_wr_ready", DW'(wr_ready_a), DW'(0));
    chk("early_last_err_len", DW'(err_len_a), DW'(1));
    @(posedge clk);
    @(negedge clk);
    chk("err_len_one_cycle", DW'(err_len_a), DW'(0));
    @(posedge clk); #1;
    push_exp(1, DW'(32'h6000), 1'b0);
    push_exp(1, DW'(32'h6001), 1'b0);
    push_exp(1, DW'(32'h5002), 1'b0);
    push_exp(1, DW'(32'h5003), 1'b1);
    do_cmd(1, 16'h8010, 1'b0);
    wait_drain(1);

    // Same-cycle same-address writes from both ports.
    fork
      do_cmd(0, 16'h0005, 1'b1);
      do_cmd(1, 16'h0005, 1'b1);
    join
    fork
      wr_beat(0, {64{8'h11}}, 1'b1);
      wr_beat(1, {64{8'h22}}, 1'b1);
    join
    @(negedge clk);
    chk("err_coll_pulse", DW'(err_coll), DW'(1));
    @(posedge clk); #1;
    push_exp(1, {64{8'h11}}, 1'b1);
    do_cmd(1, 16'h0005, 1'b0);
    wait_drain(1);

    // Asynchronous reset in the middle of a stalled 8-beat read.
    rd_ready_a = 1'b0;
    do_cmd(0, 16'hC000, 1'b0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_cmd_ready", DW'(cmd_ready_a), DW'(1));
    chk("async_rst_rd_valid", DW'(rd_valid_a), DW'(0));
    chk("async_rst_rd_data", rd_data_a, '0);
    chk("async_rst_rd_last", DW'(rd_last_a), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_ready_a = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(0, DW'(i), (i == 7));
    do_cmd(0, 16'hC000, 1'b0);
    wait_drain(0);

    repeat (3) @(posedge clk);
    #2;
    chk("err_len_a_total", DW'(cnt_elen_a), DW'(1));
    chk("err_len_b_total", DW'(cnt_elen_b), DW'(0));
    chk("err_coll_total", DW'(cnt_coll), DW'(1));
    chk("queues_empty", DW'(exp_a.size() + exp_b.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
